// File: rtl/spi_wb_master_core.sv
`default_nettype none
// ============================================================================
// Module   : spi_wb_master_core
// Purpose  : Wishbone B4 classic slave that owns a single-channel SPI master.
//            Software programs DIV, CTRL, SS and DATA, then sets CTRL.GO.
//            The engine shifts one DATA_W-bit frame, captures RX, sets the
//            sticky done flag and pulses o_tick for one clock.
// Options  : `define SPI_LOOPBACK_EN adds CTRL bit5 LOOP. With LOOP=1 the
//            engine samples its own MOSI and the o_ss_n pins stay high.
//            Without it bit5 reads 0 and i_miso is always used.
// Ports    : clk, rst_n              clock, async active-low reset
//            i_wb_* / o_wb_*         Wishbone classic slave (byte address)
//            o_wb_int                level interrupt (done & IE), registered
//            o_tick                  one-cycle pulse at frame completion
//            o_sclk/o_mosi/i_miso    SPI bus
//            o_ss_n                  active-low slave selects
// Register : 0x00 DATA, 0x04 CTRL, 0x08 DIV, 0x0C SS, 0x10 STATUS
// Revision : 1.0  initial release
// ============================================================================
module spi_wb_master_core #(
  parameter int DATA_W = 8,
  parameter int SS_W   = 4,
  parameter int DIV_W  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      i_wb_addr,
  input  logic [31:0]     i_wb_data,
  output logic [31:0]     o_wb_data,
  input  logic [3:0]      i_wb_sel,
  input  logic            i_wb_we,
  input  logic            i_wb_stb,
  input  logic            i_wb_cyc,
  output logic            o_wb_ack,
  output logic            o_wb_err,
  output logic            o_wb_int,
  output logic            o_tick,
  output logic            o_sclk,
  output logic            o_mosi,
  input  logic            i_miso,
  output logic [SS_W-1:0] o_ss_n
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_LEAD  = 2'd1;
  localparam logic [1:0] c_SHIFT = 2'd2;
  localparam logic [1:0] c_TRAIL = 2'd3;

  // Edge counter holds the number of SCLK edges already produced (0..2*DATA_W).
  localparam int               c_EW   = $clog2(2 * DATA_W) + 1;
  localparam logic [c_EW-1:0]  c_LAST = c_EW'(2 * DATA_W - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_tx_sh;
  logic [DATA_W-1:0] r_rx_sh;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  r_cnt;
  logic [SS_W-1:0]   r_ss;
  logic [c_EW-1:0]   r_edge;
  logic              r_cpol;
  logic              r_cpha;
  logic              r_ie;
  logic              r_lsb;
  logic              r_done;
  logic              r_go;
  logic              r_sclk;
  logic              r_mosi;
  logic              r_tick;
  logic              r_int;
  logic              r_ack;
  logic              r_err;
  logic [31:0]       r_rdata;
  logic              w_loop_en;

`ifdef SPI_LOOPBACK_EN
  logic r_loop;
  assign w_loop_en = r_loop;
`else
  assign w_loop_en = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Shift helpers (bit order selected by LSB_FIRST)
  // --------------------------------------------------------------------------
  function automatic logic tx_head(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] tx_next(input logic [DATA_W-1:0] v,
                                                input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic [DATA_W-1:0] rx_push(input logic [DATA_W-1:0] v,
                                                input logic b, input logic lsb);
    return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
  endfunction

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic        w_req;
  logic        w_busy;
  logic        w_addr_ok;
  logic        w_a_data;
  logic        w_a_ctrl;
  logic        w_a_div;
  logic        w_a_ss;
  logic        w_a_stat;
  logic        w_bad;
  logic        w_wr;
  logic        w_rd_ok;
  logic        w_ctrl_wr;
  logic        w_go_wr;
  logic        w_w1c;
  logic [31:0] w_mask;
  logic [31:0] w_rd;

  // A request is not re-accepted while its own ack/err is on the bus.
  assign w_req     = i_wb_cyc & i_wb_stb & ~r_ack & ~r_err;
  // r_go covers the single cycle between the GO write and the FSM leaving IDLE.
  assign w_busy    = (r_state != c_IDLE) | r_go;
  assign w_addr_ok = (i_wb_addr[1:0] == 2'b00) && (i_wb_addr[4:2] <= 3'd4);
  assign w_a_data  = (i_wb_addr[4:2] == 3'd0);
  assign w_a_ctrl  = (i_wb_addr[4:2] == 3'd1);
  assign w_a_div   = (i_wb_addr[4:2] == 3'd2);
  assign w_a_ss    = (i_wb_addr[4:2] == 3'd3);
  assign w_a_stat  = (i_wb_addr[4:2] == 3'd4);
  assign w_bad     = ~w_addr_ok |
                     (i_wb_we & w_busy & (w_a_data | w_a_ctrl | w_a_div));
  assign w_wr      = w_req & i_wb_we & ~w_bad;
  assign w_rd_ok   = w_req & ~i_wb_we & ~w_bad;
  assign w_mask    = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}},
                      {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
  // All CTRL/STATUS bits live in byte lane 0.
  assign w_ctrl_wr = w_wr & w_a_ctrl & i_wb_sel[0];
  assign w_go_wr   = w_ctrl_wr & i_wb_data[0];
  assign w_w1c     = w_wr & w_a_stat & i_wb_sel[0] & i_wb_data[1];

  logic [31:0] w_tx_m;
  logic [31:0] w_div_m;
  logic [31:0] w_ss_m;
  assign w_tx_m  = (32'(r_tx)  & ~w_mask) | (i_wb_data & w_mask);
  assign w_div_m = (32'(r_div) & ~w_mask) | (i_wb_data & w_mask);
  assign w_ss_m  = (32'(r_ss)  & ~w_mask) | (i_wb_data & w_mask);

  always_comb begin
    w_rd = 32'd0;
    case (i_wb_addr[4:2])
      3'd0: w_rd = 32'(r_rx);
      3'd1: w_rd = {26'd0, w_loop_en, r_lsb, r_ie, r_cpha, r_cpol, w_busy};
      3'd2: w_rd = 32'(r_div);
      3'd3: w_rd = 32'(r_ss);
      3'd4: w_rd = {30'd0, r_done, w_busy};
      default: w_rd = 32'd0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Engine decode
  // --------------------------------------------------------------------------
  logic w_half;
  logic w_edge;
  logic w_lead;
  logic w_sample;
  logic w_shift;
  logic w_frame_done;
  logic w_miso;

  assign w_half       = (r_cnt == r_div);
  assign w_edge       = w_half & ((r_state == c_LEAD) | (r_state == c_SHIFT));
  // The upcoming edge is odd-numbered (leading) when an even count is done.
  assign w_lead       = ~r_edge[0];
  assign w_sample     = w_edge & (r_cpha ? ~w_lead : w_lead);
  // In CPHA=0 the last trailing edge has no further bit to present.
  assign w_shift      = w_edge & (r_cpha ? w_lead : (~w_lead & (r_edge != c_LAST)));
  assign w_frame_done = (r_state == c_TRAIL) & w_half;
  assign w_miso       = w_loop_en ? r_mosi : i_miso;

  // --------------------------------------------------------------------------
  // Register file and bus response
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
      r_go    <= 1'b0;
      r_tx    <= '0;
      r_div   <= '0;
      r_ss    <= '0;
      r_cpol  <= 1'b0;
      r_cpha  <= 1'b0;
      r_ie    <= 1'b0;
      r_lsb   <= 1'b0;
      r_done  <= 1'b0;
      r_int   <= 1'b0;
`ifdef SPI_LOOPBACK_EN
      r_loop  <= 1'b0;
`endif
    end else begin
      r_ack   <= w_req & ~w_bad;
      r_err   <= w_req & w_bad;
      r_rdata <= w_rd_ok ? w_rd : 32'd0;
      r_go    <= w_go_wr;
      if (w_wr & w_a_data) r_tx  <= DATA_W'(w_tx_m);
      if (w_wr & w_a_div)  r_div <= DIV_W'(w_div_m);
      if (w_wr & w_a_ss)   r_ss  <= SS_W'(w_ss_m);
      if (w_ctrl_wr) begin
        r_cpol <= i_wb_data[1];
        r_cpha <= i_wb_data[2];
        r_ie   <= i_wb_data[3];
        r_lsb  <= i_wb_data[4];
`ifdef SPI_LOOPBACK_EN
        r_loop <= i_wb_data[5];
`endif
      end
      // Completion outranks a simultaneous W1C.
      if (w_frame_done)       r_done <= 1'b1;
      else if (w_go_wr)       r_done <= 1'b0;
      else if (w_w1c)         r_done <= 1'b0;
      r_int <= r_done & r_ie;
    end
  end

  // --------------------------------------------------------------------------
  // SPI engine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_edge  <= '0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_tx_sh <= '0;
      r_rx_sh <= '0;
      r_rx    <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (r_go) begin
            r_state <= c_LEAD;
            r_cnt   <= '0;
            r_edge  <= '0;
            r_sclk  <= r_cpol;
            r_rx_sh <= '0;
            if (!r_cpha) begin
              // CPHA=0 presents the first bit before the first edge.
              r_mosi  <= tx_head(r_tx, r_lsb);
              r_tx_sh <= tx_next(r_tx, r_lsb);
            end else begin
              r_tx_sh <= r_tx;
            end
          end
        end
        c_LEAD, c_SHIFT: begin
          if (w_half) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
            r_edge <= r_edge + 1'b1;
            if (r_state == c_LEAD)    r_state <= c_SHIFT;
            else if (r_edge == c_LAST) r_state <= c_TRAIL;
            if (w_sample) r_rx_sh <= rx_push(r_rx_sh, w_miso, r_lsb);
            if (w_shift) begin
              r_mosi  <= tx_head(r_tx_sh, r_lsb);
              r_tx_sh <= tx_next(r_tx_sh, r_lsb);
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_TRAIL: begin
          if (w_half) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_rx    <= r_rx_sh;
            r_tick  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // SCLK follows CPOL directly while idle so a mode change shows immediately.
  assign o_sclk    = (r_state == c_IDLE) ? r_cpol : r_sclk;
  assign o_mosi    = r_mosi;
  // Derived from the async-reset state, so reset releases SS without a clock.
  assign o_ss_n    = ~(r_ss & {SS_W{(r_state != c_IDLE) & ~w_loop_en}});
  assign o_tick    = r_tick;
  assign o_wb_ack  = r_ack;
  assign o_wb_err  = r_err;
  assign o_wb_data = r_rdata;
  assign o_wb_int  = r_int;

endmodule
`default_nettype wire

// File: tb/tb_spi_wb_master_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_wb_master_core
// Purpose  : Self-checking bench for spi_wb_master_core. Register accesses run
//            from a vector table; bus responses and SPI frames are checked
//            against expectation queues filled when stimulus is issued.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_wb_master_core;

  localparam logic [4:0] A_DATA = 5'h00;
  localparam logic [4:0] A_CTRL = 5'h04;
  localparam logic [4:0] A_DIV  = 5'h08;
  localparam logic [4:0] A_SS   = 5'h0C;
  localparam logic [4:0] A_STAT = 5'h10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  i_wb_addr = '0;
  logic [31:0] i_wb_data = '0;
  logic [31:0] o_wb_data;
  logic [3:0]  i_wb_sel = '0;
  logic        i_wb_we = 1'b0;
  logic        i_wb_stb = 1'b0;
  logic        i_wb_cyc = 1'b0;
  logic        o_wb_ack, o_wb_err, o_wb_int, o_tick, o_sclk, o_mosi;
  logic        i_miso = 1'b0;
  logic [3:0]  o_ss_n;

  always #5 clk = ~clk;

  spi_wb_master_core #(.DATA_W(8), .SS_W(4), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .o_wb_data(o_wb_data),
    .i_wb_sel(i_wb_sel), .i_wb_we(i_wb_we), .i_wb_stb(i_wb_stb),
    .i_wb_cyc(i_wb_cyc), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
    .o_wb_int(o_wb_int), .o_tick(o_tick), .o_sclk(o_sclk), .o_mosi(o_mosi),
    .i_miso(i_miso), .o_ss_n(o_ss_n)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- bus response scoreboard ----------------
  typedef struct packed { logic err; logic [31:0] data; } rsp_t;
  rsp_t rsp_q[$];

  always @(negedge clk) begin
    if (o_wb_ack || o_wb_err) begin
      if (rsp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wb_unexpected: got ack=%0b err=%0b with nothing pending", o_wb_ack, o_wb_err);
      end else begin
        rsp_t t;
        t = rsp_q.pop_front();
        check("wb_resp", {30'd0, o_wb_ack, o_wb_err}, {30'd0, ~t.err, t.err});
        check("wb_rdata", o_wb_data, t.data);
      end
    end
  end

  task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic e, input logic [31:0] r);
    rsp_t t;
    bit   got;
    @(negedge clk);
    t.err = e; t.data = r;
    rsp_q.push_back(t);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
    i_wb_addr = a; i_wb_data = d; i_wb_sel = s;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clk); #1;
      if (o_wb_ack || o_wb_err) got = 1'b1;
    end
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL wb_timeout: addr 0x%0h got no ack/err required one", a);
      void'(rsp_q.pop_back());
    end
  endtask

  // ---------------- tick / sclk monitors ----------------
  int tick_total  = 0;
  int double_tick = 0;
  logic prev_tick = 1'b0;
  always @(negedge clk) begin
    if (o_tick) tick_total++;
    if (o_tick && prev_tick) double_tick++;
    prev_tick = o_tick;
  end

  int rise_t[64];
  int n_rise = 0;
  always @(posedge o_sclk) begin
    if (n_rise < 64) rise_t[n_rise] = int'($time);
    n_rise++;
  end

  task automatic wait_tick();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 3000 && !got; k++) begin
      @(negedge clk);
      if (o_tick) got = 1'b1;
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL tick_timeout: got no tick required one");
    end
  endtask

  // ---------------- SPI slave model + frame scoreboard ----------------
  logic       m_cpol = 1'b0, m_cpha = 1'b0, m_lsb = 1'b0;
  logic [7:0] slave_tx = 8'h00;
  logic [7:0] mosi_cap = 8'h00;
  logic       first_bit = 1'b0;
  logic       prev_ss = 1'b1, prev_sclk = 1'b0;
  int         s_tx_i = 0, s_rx_i = 0;
  logic [7:0] frame_q[$];

  function automatic logic sbit(input int i);
    return m_lsb ? slave_tx[i] : slave_tx[7-i];
  endfunction

  always @(o_sclk or o_ss_n) begin
    if (o_ss_n[0] !== prev_ss) begin
      if (prev_ss === 1'b1 && o_ss_n[0] === 1'b0) begin
        s_tx_i = 0; s_rx_i = 0; mosi_cap = 8'h00;
        if (!m_cpha) begin i_miso = sbit(0); s_tx_i = 1; end
      end else if (prev_ss === 1'b0 && o_ss_n[0] === 1'b1) begin
        if (frame_q.size() > 0) begin
          logic [7:0] e;
          e = frame_q.pop_front();
          check("mosi_frame", 32'(mosi_cap), 32'(e));
        end
      end
      prev_ss = o_ss_n[0];
    end else if (o_sclk !== prev_sclk && o_ss_n[0] === 1'b0) begin
      // Leading edge: SCLK moves away from CPOL.
      if ((o_sclk !== m_cpol) == !m_cpha) begin
        if (s_rx_i == 0) first_bit = o_mosi;
        if (s_rx_i < 8) mosi_cap[m_lsb ? s_rx_i : 7 - s_rx_i] = o_mosi;
        s_rx_i++;
      end else if (s_tx_i < 8) begin
        i_miso = sbit(s_tx_i);
        s_tx_i++;
      end
    end
    prev_sclk = o_sclk;
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        err;
    logic [31:0] rdata;
  } vec_t;
  vec_t vt[20];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nack, ncons, base, tb0;
    logic pa;

    vt[0]  = '{0, A_STAT, 32'h0,        4'hF, 0, 32'h0};
    vt[1]  = '{0, A_CTRL, 32'h0,        4'hF, 0, 32'h0};
    vt[2]  = '{0, A_DIV,  32'h0,        4'hF, 0, 32'h0};
    vt[3]  = '{0, A_DATA, 32'h0,        4'hF, 0, 32'h0};
    vt[4]  = '{1, A_DIV,  32'h1,        4'hF, 0, 32'h0};
    vt[5]  = '{0, A_DIV,  32'h0,        4'hF, 0, 32'h1};
    vt[6]  = '{1, A_SS,   32'h1,        4'hF, 0, 32'h0};
    vt[7]  = '{0, A_SS,   32'h0,        4'hF, 0, 32'h1};
    vt[8]  = '{1, A_DATA, 32'hFFFFFFA5, 4'hF, 0, 32'h0};
    vt[9]  = '{0, 5'h14,  32'h0,        4'hF, 1, 32'h0};
    vt[10] = '{0, 5'h02,  32'h0,        4'hF, 1, 32'h0};
    vt[11] = '{1, 5'h02,  32'h7,        4'hF, 1, 32'h0};
    vt[12] = '{1, A_DIV,  32'h1234,     4'h0, 0, 32'h0};
    vt[13] = '{1, A_DIV,  32'hFF00,     4'h2, 0, 32'h0};
    vt[14] = '{0, A_DIV,  32'h0,        4'hF, 0, 32'hFF01};
    vt[15] = '{1, A_DIV,  32'h1,        4'hF, 0, 32'h0};
    vt[16] = '{0, A_DIV,  32'h0,        4'hF, 0, 32'h1};
    vt[17] = '{1, A_CTRL, 32'h20,       4'h1, 0, 32'h0};
`ifdef SPI_LOOPBACK_EN
    vt[18] = '{0, A_CTRL, 32'h0,        4'hF, 0, 32'h20};
`else
    vt[18] = '{0, A_CTRL, 32'h0,        4'hF, 0, 32'h0};
`endif
    vt[19] = '{1, A_CTRL, 32'h0,        4'hF, 0, 32'h0};

    // Reset values before any clock edge.
    #1;
    check("rst_ack_err_int_tick", {28'd0, o_wb_ack, o_wb_err, o_wb_int, o_tick}, 32'h0);
    check("rst_rdata", o_wb_data, 32'h0);
    check("rst_sclk_mosi", {30'd0, o_sclk, o_mosi}, 32'h0);
    check("rst_ss_n", 32'(o_ss_n), 32'hF);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++)
      wb(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].sel, vt[i].err, vt[i].rdata);

    // Held cyc/stb: acks on alternate cycles only.
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rsp_t t; t.err = 1'b0; t.data = 32'h0; rsp_q.push_back(t);
    end
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = A_STAT;
    nack = 0; ncons = 0; pa = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (o_wb_ack) begin nack++; if (pa) ncons++; end
      pa = o_wb_ack;
    end
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    check("held_ack_count", 32'(nack), 32'd5);
    check("held_ack_consecutive", 32'(ncons), 32'd0);

    // Frame 1: mode 0, MSB first, DIV=1, slave returns 0x3C.
    m_cpol = 0; m_cpha = 0; m_lsb = 0; slave_tx = 8'h3C;
    frame_q.push_back(8'hA5);
    base = n_rise; tb0 = tick_total;
    wb(1, A_CTRL, 32'h1, 4'hF, 0, 32'h0);
    wb(1, A_DIV,  32'h5, 4'hF, 1, 32'h0);
    wb(0, A_DIV,  32'h0, 4'hF, 0, 32'h1);
    wb(1, A_CTRL, 32'h1, 4'hF, 1, 32'h0);
    wb(0, A_STAT, 32'h0, 4'hF, 0, 32'h1);
    check("ss_busy", 32'(o_ss_n), 32'hE);
    wait_tick();
    repeat (2) @(negedge clk);
    check("tick_once", 32'(tick_total - tb0), 32'd1);
    check("sclk_period_div1", 32'(rise_t[base+1] - rise_t[base]), 32'd40);
    check("int_ie_off", 32'(o_wb_int), 32'h0);
    wb(0, A_DATA, 32'h0, 4'hF, 0, 32'h3C);
    wb(0, A_STAT, 32'h0, 4'hF, 0, 32'h2);

    // Frame 2: mode 3, LSB first, IE.
    m_cpol = 1; m_cpha = 1; m_lsb = 1; slave_tx = 8'h81;
    wb(1, A_CTRL, 32'h2, 4'hF, 0, 32'h0);
    @(negedge clk);
    check("sclk_idle_cpol1", 32'(o_sclk), 32'h1);
    wb(1, A_DATA, 32'h01, 4'hF, 0, 32'h0);
    frame_q.push_back(8'h01);
    wb(1, A_CTRL, 32'h1F, 4'hF, 0, 32'h0);
    wait_tick();
    repeat (3) @(negedge clk);
    check("mode3_first_bit", 32'(first_bit), 32'h1);
    check("int_set", 32'(o_wb_int), 32'h1);
    wb(0, A_DATA, 32'h0, 4'hF, 0, 32'h81);
    wb(1, A_STAT, 32'h2, 4'hF, 0, 32'h0);
    repeat (2) @(negedge clk);
    check("int_cleared", 32'(o_wb_int), 32'h0);
    wb(0, A_STAT, 32'h0, 4'hF, 0, 32'h0);

    // Frame 3: reset at half-frame aborts without a tick.
    m_cpol = 0; m_cpha = 0; m_lsb = 0; slave_tx = 8'hFF;
    wb(1, A_DATA, 32'h33, 4'hF, 0, 32'h0);
    wb(1, A_CTRL, 32'h1,  4'hF, 0, 32'h0);
    repeat (16) @(negedge clk);
    check("ss_before_abort", 32'(o_ss_n), 32'hE);
    tb0 = tick_total;
    #2 rst_n = 1'b0;
    #1;
    check("abort_ss_n", 32'(o_ss_n), 32'hF);
    check("abort_sclk", 32'(o_sclk), 32'h0);
    repeat (40) @(negedge clk);
    check("abort_no_tick", 32'(tick_total - tb0), 32'd0);
    rst_n = 1'b1;

    // Fresh frame after reset: DIV back to 0 gives clk/2.
    slave_tx = 8'h5A;
    wb(1, A_SS,   32'h1,  4'hF, 0, 32'h0);
    wb(1, A_DATA, 32'hC3, 4'hF, 0, 32'h0);
    frame_q.push_back(8'hC3);
    base = n_rise;
    wb(1, A_CTRL, 32'h1,  4'hF, 0, 32'h0);
    wait_tick();
    repeat (2) @(negedge clk);
    check("sclk_period_div0", 32'(rise_t[base+1] - rise_t[base]), 32'd20);
    wb(0, A_DATA, 32'h0, 4'hF, 0, 32'h5A);
    wb(0, A_STAT, 32'h0, 4'hF, 0, 32'h2);

`ifdef SPI_LOOPBACK_EN
    wb(1, A_DATA, 32'h5A, 4'hF, 0, 32'h0);
    wb(1, A_CTRL, 32'h21, 4'hF, 0, 32'h0);
    repeat (4) @(negedge clk);
    check("loop_ss_high", 32'(o_ss_n), 32'hF);
    wait_tick();
    wb(0, A_DATA, 32'h0, 4'hF, 0, 32'h5A);
`endif

    repeat (4) @(negedge clk);
    check("tick_width", 32'(double_tick), 32'd0);
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    check("frame_queue_drained", 32'(frame_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
